// File: rtl/floor_call_register_if.sv
// Bundle between the call-button block and the movement controller: raw buttons and
// car position in, call LEDs, service pulses and direction hints out.
interface floor_call_register_if #(
  parameter int NUM_FLOORS = 3,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
);
  logic [NUM_FLOORS-1:0] buttons;
  logic [FLOOR_W-1:0]    floor;
  logic                  move_handler;
  logic [NUM_FLOORS-1:0] leds;
  logic [NUM_FLOORS-1:0] served;
  logic                  pending_above;
  logic                  pending_below;
  logic                  pending_any;

  modport master (
    output buttons, floor, move_handler,
    input  leds, served, pending_above, pending_below, pending_any
  );

  modport slave (
    input  buttons, floor, move_handler,
    output leds, served, pending_above, pending_below, pending_any
  );
endinterface

// File: rtl/floor_call_register.sv
// N-floor call register: synchronise + debounce each button, latch calls, clear on service.
// Optional build macro FLOOR_CALL_CANCEL_EN: pressing a lit call away from the car cancels it.
module floor_call_register #(
  parameter int NUM_FLOORS      = 3,
  parameter int FLOOR_W         = $clog2(NUM_FLOORS),
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic                  clk,
  input logic                  button_reset,
  floor_call_register_if.slave bus
);

  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;

  logic [NUM_FLOORS-1:0] s1;
  logic [NUM_FLOORS-1:0] s2;
  logic [NUM_FLOORS-1:0] db;
  logic [NUM_FLOORS-1:0] db_d;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] at_floor;
  logic [NUM_FLOORS-1:0] leds_q;
  logic [NUM_FLOORS-1:0] served_q;
  logic [NUM_FLOORS-1:0] leds_next;
  logic [NUM_FLOORS-1:0] served_next;
  logic                  above;
  logic                  below;

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.buttons;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign db = s2;
    end else begin : g_debounce
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0]         cnt [NUM_FLOORS];
      logic [NUM_FLOORS-1:0] db_q;

      // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
      always_ff @(posedge clk or posedge button_reset) begin
        if (button_reset) begin
          db_q <= '0;
          for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_FLOORS; i++) begin
            if (s2[i] == db_q[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              db_q[i] <= s2[i];
              cnt[i]  <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end

      assign db = db_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) db_d <= '0;
    else              db_d <= db;
  end

  assign press = db & ~db_d;

  // An out-of-range floor simply matches no channel.
  always_comb begin
    at_floor = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      at_floor[i] = !bus.move_handler && (int'(bus.floor) == i);
    end
  end

  always_comb begin
    leds_next   = leds_q;
    served_next = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (at_floor[i]) begin
        leds_next[i]   = 1'b0;
        served_next[i] = leds_q[i] | press[i];
      end else if (press[i]) begin
`ifdef FLOOR_CALL_CANCEL_EN
        leds_next[i] = ~leds_q[i];
`else
        leds_next[i] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      leds_q   <= '0;
      served_q <= '0;
    end else begin
      leds_q   <= leds_next;
      served_q <= served_next;
    end
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (leds_q[i] && (i > int'(bus.floor))) above = 1'b1;
      if (leds_q[i] && (i < int'(bus.floor))) below = 1'b1;
    end
  end

  assign bus.leds          = leds_q;
  assign bus.served        = served_q;
  assign bus.pending_above = above;
  assign bus.pending_below = below;
  assign bus.pending_any   = |leds_q;

endmodule
